pipe_interlock_ctrl: RTL and testbench

Central interlock/scheduling controller for the 5-stage pipeline. It produces the stall signals for the fetch and decode stage registers, and the EX bubble signal. It detects load-use hazards and sequences the multi-cycle divider so HI/LO consumers wait for the result. It also exposes a stall performance counter. The MEM/WB results are forwarded by the bypass network; only a load currently in EX causes an interlock.

---
 rtl/pipe_interlock_ctrl_pkg.sv | 13 +
 rtl/pipe_interlock_ctrl_div_sequencer.sv | 76 +++++++
 rtl/pipe_interlock_ctrl.sv | 79 +++++++
 tb/tb_pipe_interlock_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_interlock_ctrl_pkg.sv
// rtl/pipe_interlock_ctrl_pkg.sv - shared types and constants for the pipeline interlock controller
package pipe_interlock_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [31:0] NOP_INSN       = 32'h0000_0000;
    localparam int          REG_AW_DEFAULT = 5;

endpackage

// File: rtl/pipe_interlock_ctrl_div_sequencer.sv
// rtl/pipe_interlock_ctrl_div_sequencer.sv - multi-cycle divider launch/busy/done sequencer
module pipe_interlock_ctrl_div_sequencer
    import pipe_interlock_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_req_i,
    input  logic       flush_i,
    output logic       div_start_o,
    output logic       div_busy_o,
    output logic       div_done_o,
    output div_state_e state_o
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_raw;
    logic             done_raw;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_raw = 1'b0;
        done_raw  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start_req_i && !flush_i) begin
                    start_raw = 1'b1;
                    state_d   = DIV_BUSY;
                    cnt_d     = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                done_raw = 1'b1;
                state_d  = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        // A flush aborts any divide in flight; its result is never reported.
        if (flush_i) begin
            state_d  = DIV_IDLE;
            cnt_d    = '0;
            done_raw = 1'b0;
        end
    end

    assign div_start_o = resetn & start_raw;
    assign div_busy_o  = resetn & (state_q != DIV_IDLE);
    assign div_done_o  = resetn & done_raw;
    assign state_o     = state_q;

endmodule

// File: rtl/pipe_interlock_ctrl.sv
// rtl/pipe_interlock_ctrl.sv - load-use / HI-LO interlock, EX bubble and stall counter for the 5-stage pipe
module pipe_interlock_ctrl
    import pipe_interlock_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33,
    parameter int REG_AW     = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] de_rs,
    input  logic [REG_AW-1:0] de_rt,
    input  logic              de_use_rs,
    input  logic              de_use_rt,
    input  logic              de_is_hilo,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_is_div,
    input  logic              ex_flush,
    output logic              fe_stall,
    output logic              de_stall,
    output logic              ex_bubble,
    output logic              div_start,
    output logic              div_busy,
    output logic              div_done,
    output logic [31:0]       stall_count
);

    div_state_e  div_state;
    logic        load_use;
    logic        hilo_wait;
    logic        hazard;
    logic [31:0] stall_count_q, stall_count_d;

    pipe_interlock_ctrl_div_sequencer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk         (clk),
        .resetn      (resetn),
        .start_req_i (ex_valid & ex_is_div),
        .flush_i     (ex_flush),
        .div_start_o (div_start),
        .div_busy_o  (div_busy),
        .div_done_o  (div_done),
        .state_o     (div_state)
    );

    // Only a load still in EX interlocks; MEM/WB values reach DE through the bypass.
    assign load_use = de_valid & ex_valid & ex_is_load & (ex_dest != '0) &
                      ((de_use_rs & (de_rs == ex_dest)) | (de_use_rt & (de_rt == ex_dest)));

    assign hilo_wait = de_valid & de_is_hilo &
                       ((div_state == DIV_BUSY) | (div_state == DIV_DONE));

    assign hazard    = load_use | hilo_wait;

    assign fe_stall  = resetn & ~ex_flush & hazard;
    assign de_stall  = resetn & ~ex_flush & hazard;
    assign ex_bubble = resetn & (ex_flush | hazard);

    always_comb begin
        stall_count_d = stall_count_q;
        if (de_stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
// tb/tb_pipe_interlock_ctrl.sv - directed self-checking bench for pipe_interlock_ctrl
module tb_pipe_interlock_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        de_valid, de_use_rs, de_use_rt, de_is_hilo;
    logic [4:0]  de_rs, de_rt, ex_dest;
    logic        ex_valid, ex_is_load, ex_is_div, ex_flush;
    logic        fe_stall, de_stall, ex_bubble, div_start, div_busy, div_done;
    logic [31:0] stall_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt;
    int          busy_n, done_n;

    always #5 clk = ~clk;

    pipe_interlock_ctrl #(.DIV_CYCLES(33), .REG_AW(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .de_valid    (de_valid),
        .de_rs       (de_rs),
        .de_rt       (de_rt),
        .de_use_rs   (de_use_rs),
        .de_use_rt   (de_use_rt),
        .de_is_hilo  (de_is_hilo),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_dest     (ex_dest),
        .ex_is_div   (ex_is_div),
        .ex_flush    (ex_flush),
        .fe_stall    (fe_stall),
        .de_stall    (de_stall),
        .ex_bubble   (ex_bubble),
        .div_start   (div_start),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        de_valid = 0; de_rs = 0; de_rt = 0; de_use_rs = 0; de_use_rt = 0; de_is_hilo = 0;
        ex_valid = 0; ex_is_load = 0; ex_dest = 0; ex_is_div = 0; ex_flush = 0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        ex_valid = 1; ex_is_load = 1; ex_dest = r;
        de_valid = 1; de_rs = r; de_use_rs = 1;
    endtask

    initial begin
        clear_inputs();
        resetn = 0;

        // Reset: outputs held low even with a hazard and a div presented.
        set_load_use(5'd5);
        tick(); tick();
        ex_is_div = 1;
        #1;
        chk("rst_fe_stall", {31'b0, fe_stall}, 32'd0);
        chk("rst_ex_bubble", {31'b0, ex_bubble}, 32'd0);
        chk("rst_div_start", {31'b0, div_start}, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        clear_inputs();
        resetn = 1;
        tick();
        exp_cnt = 0;
        chk("idle_div_busy", {31'b0, div_busy}, 32'd0);
        chk("idle_stall_count", stall_count, exp_cnt);

        // Load-use on rs.
        set_load_use(5'd5);
        #1;
        chk("lu_fe_stall", {31'b0, fe_stall}, 32'd1);
        chk("lu_de_stall", {31'b0, de_stall}, 32'd1);
        chk("lu_ex_bubble", {31'b0, ex_bubble}, 32'd1);
        tick();
        exp_cnt = 1;
        ex_is_load = 0;
        #1;
        chk("lu_released", {31'b0, de_stall}, 32'd0);
        chk("lu_count", stall_count, exp_cnt);

        // Vectors that must not stall, and one rt hit that must.
        clear_inputs(); set_load_use(5'd0); #1;
        chk("lu_dest0", {31'b0, de_stall}, 32'd0);
        clear_inputs(); ex_valid = 1; ex_is_load = 1; ex_dest = 5;
        de_valid = 1; de_rt = 5; de_use_rt = 0; #1;
        chk("rt_unused", {31'b0, de_stall}, 32'd0);
        de_use_rt = 1; #1;
        chk("rt_used", {31'b0, de_stall}, 32'd1);
        ex_is_load = 0; #1;
        chk("non_load", {31'b0, de_stall}, 32'd0);
        ex_is_load = 1; de_valid = 0; #1;
        chk("de_invalid", {31'b0, ex_bubble}, 32'd0);
        clear_inputs();
        tick();
        chk("no_extra_count", stall_count, exp_cnt);

        // Divide with a mflo waiting in DE.
        ex_valid = 1; ex_is_div = 1; de_valid = 1; de_is_hilo = 1;
        #1;
        chk("div_start_T", {31'b0, div_start}, 32'd1);
        chk("div_nostall_T", {31'b0, de_stall}, 32'd0);
        tick();
        ex_valid = 0; ex_is_div = 0;
        for (int k = 1; k <= 34; k++) begin
            #1;
            chk($sformatf("div_busy_%0d", k), {31'b0, div_busy}, 32'd1);
            chk($sformatf("div_done_%0d", k), {31'b0, div_done}, (k == 34) ? 32'd1 : 32'd0);
            chk($sformatf("div_stall_%0d", k), {31'b0, de_stall}, 32'd1);
            tick();
        end
        exp_cnt = 35;
        chk("div_idle_after", {31'b0, div_busy}, 32'd0);
        chk("div_released", {31'b0, de_stall}, 32'd0);
        chk("div_count", stall_count, exp_cnt);
        clear_inputs();

        // Flush at BUSY cycle 10.
        ex_valid = 1; ex_is_div = 1;
        tick();
        clear_inputs();
        repeat (9) tick();
        chk("fl_busy_before", {31'b0, div_busy}, 32'd1);
        ex_flush = 1; de_valid = 1; de_is_hilo = 1;
        #1;
        chk("fl_fe_stall", {31'b0, fe_stall}, 32'd0);
        chk("fl_de_stall", {31'b0, de_stall}, 32'd0);
        chk("fl_ex_bubble", {31'b0, ex_bubble}, 32'd1);
        tick();
        clear_inputs();
        #1;
        chk("fl_idle", {31'b0, div_busy}, 32'd0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_done) done_n++;
            tick();
        end
        chk("fl_no_done", done_n, 32'd0);
        chk("fl_count", stall_count, exp_cnt);

        // Flush while a div sits in EX with the FSM idle: no launch.
        ex_valid = 1; ex_is_div = 1; ex_flush = 1; #1;
        chk("fl_idle_start", {31'b0, div_start}, 32'd0);
        tick();
        clear_inputs(); #1;
        chk("fl_idle_busy", {31'b0, div_busy}, 32'd0);

        // Load-use and hilo_wait together count once.
        ex_valid = 1; ex_is_div = 1;
        tick();
        clear_inputs();
        set_load_use(5'd7);
        de_is_hilo = 1;
        #1;
        chk("both_stall", {31'b0, de_stall}, 32'd1);
        tick();
        exp_cnt = exp_cnt + 1;
        chk("both_count", stall_count, exp_cnt);

        // Reset during BUSY.
        clear_inputs();
        repeat (3) tick();
        resetn = 0;
        tick();
        chk("rb_busy", {31'b0, div_busy}, 32'd0);
        chk("rb_done", {31'b0, div_done}, 32'd0);
        chk("rb_count", stall_count, 32'd0);
        resetn = 1;
        tick();
        ex_valid = 1; ex_is_div = 1; #1;
        chk("rb_restart", {31'b0, div_start}, 32'd1);
        tick();
        clear_inputs();
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 50; i++) begin
            if (div_busy && !div_done) busy_n++;
            if (div_done) done_n++;
            tick();
        end
        chk("rb_busy_cycles", busy_n, 32'd33);
        chk("rb_done_pulses", done_n, 32'd1);

        // Counter wrap.
        force dut.stall_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count_q;
        #1;
        chk("wrap_pre", stall_count, 32'hFFFF_FFFF);
        set_load_use(5'd9);
        tick();
        chk("wrap_zero", stall_count, 32'd0);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
